// File: rtl/memio_responder_pkg.sv
// memio_responder_pkg: shared definitions for the memory/IO responder.
// Holds the bus width, IO page decode constants, IO register offsets
// and the UART transmitter state encoding.
package memio_responder_pkg;

   localparam int unsigned BUS_W      = 32;
   localparam int unsigned IO_SEL_BIT = 22;
   localparam int unsigned IO_REG_W   = 3;
   localparam int unsigned LANES      = BUS_W / 8;

   // IO register offsets, selected by mem_addr[4:2]
   typedef enum logic [IO_REG_W-1:0] {
      IO_LEDS        = 3'd0,
      IO_UART_DATA   = 3'd1,
      IO_UART_STATUS = 3'd2,
      IO_CYCLES      = 3'd3
   } io_reg_e;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/memio_responder_if.sv
// memio_responder_if: core-side memory bus.
//   mem_addr  : byte address
//   mem_wdata : lane-replicated write data
//   mem_rstrb : one-cycle read strobe
//   mem_wmask : byte-lane write enables (0 = no write)
//   mem_rdata : registered read data
interface memio_responder_if;
   import memio_responder_pkg::*;

   logic [BUS_W-1:0] mem_addr;
   logic [BUS_W-1:0] mem_wdata;
   logic             mem_rstrb;
   logic [LANES-1:0] mem_wmask;
   logic [BUS_W-1:0] mem_rdata;

   modport master (
      output mem_addr, mem_wdata, mem_rstrb, mem_wmask,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_rstrb, mem_wmask,
      output mem_rdata
   );

endinterface

// File: rtl/memio_responder_uart.sv
// uart_tx_8n1: 8N1 serial transmitter.
//   clk, rstn : clock, async active-low reset
//   start     : request to send data; ignored while busy
//   data      : byte to send, LSB first
//   busy      : frame in progress (registered)
//   tx        : serial line, idle high (registered)
module uart_tx_8n1
   import memio_responder_pkg::*;
#(
   parameter int unsigned CLK_DIV = 868
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       tx
);

   localparam int unsigned BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   uart_state_e       state, state_next;
   logic [BAUD_W-1:0] baud, baud_next;
   logic [2:0]        bit_cnt, bit_next;
   logic [7:0]        shift, shift_next;
   logic              tx_next, busy_next, terminal_c;

   assign terminal_c = (baud == BAUD_W'(CLK_DIV - 1));

   // State, counters and registered line outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= UART_IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= state_next;
         baud    <= baud_next;
         bit_cnt <= bit_next;
         shift   <= shift_next;
         tx      <= tx_next;
         busy    <= busy_next;
      end
   end

   // Next state; a start at the final stop-bit edge chains straight into a new frame
   always_comb begin
      state_next = state;
      baud_next  = baud;
      bit_next   = bit_cnt;
      shift_next = shift;
      tx_next    = 1'b1;
      busy_next  = 1'b0;

      case (state)
         UART_IDLE: begin
            if (start) begin
               state_next = UART_START;
               baud_next  = '0;
               shift_next = data;
            end
         end
         UART_START: begin
            if (terminal_c) begin
               state_next = UART_DATA;
               baud_next  = '0;
               bit_next   = '0;
            end else begin
               baud_next = baud + BAUD_W'(1);
            end
         end
         UART_DATA: begin
            if (terminal_c) begin
               baud_next  = '0;
               shift_next = {1'b0, shift[7:1]};
               if (bit_cnt == 3'd7) begin
                  state_next = UART_STOP;
               end else begin
                  bit_next = bit_cnt + 3'd1;
               end
            end else begin
               baud_next = baud + BAUD_W'(1);
            end
         end
         UART_STOP: begin
            if (terminal_c) begin
               baud_next = '0;
               if (start) begin
                  state_next = UART_START;
                  shift_next = data;
               end else begin
                  state_next = UART_IDLE;
               end
            end else begin
               baud_next = baud + BAUD_W'(1);
            end
         end
         default: state_next = UART_IDLE;
      endcase

      // Line level follows the state being entered so tx changes on the advancing edge
      case (state_next)
         UART_START: tx_next = 1'b0;
         UART_DATA:  tx_next = shift_next[0];
         default:    tx_next = 1'b1;
      endcase
      busy_next = (state_next != UART_IDLE);
   end

endmodule

// File: rtl/memio_responder.sv
// memio_responder: RAM + IO page responder for the RV32I core bus.
//   clk, rstn : clock, async active-low reset
//   bus       : core memory bus (slave side); mem_rdata registered
//   leds      : LED register (IO offset 0)
//   uart_tx   : 8N1 serial output, idle high
// Decode: mem_addr[22]=0 RAM (word indexed, aliases), =1 IO page at mem_addr[4:2].
module memio_responder
   import memio_responder_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter string       INIT_FILE = "",
   parameter int unsigned CLK_DIV   = 868
) (
   input  logic                clk,
   input  logic                rstn,
   memio_responder_if.slave    bus,
   output logic [7:0]          leds,
   output logic                uart_tx
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);

   logic [BUS_W-1:0]    ram [MEM_WORDS];
   logic [BUS_W-1:0]    cycles;
   logic [BUS_W-1:0]    rdata_next_c;
   logic                io_sel_c;
   logic                uart_start_c;
   logic                uart_busy;
   logic                unused_c;
   logic [IO_REG_W-1:0] reg_sel_c;
   logic [IDX_W-1:0]    word_idx_c;

   assign io_sel_c     = bus.mem_addr[IO_SEL_BIT];
   assign reg_sel_c    = bus.mem_addr[4:2];
   assign word_idx_c   = bus.mem_addr[IDX_W+1:2];
   assign uart_start_c = io_sel_c && (reg_sel_c == IO_UART_DATA) && (|bus.mem_wmask);
   assign unused_c     = ^{bus.mem_addr, bus.mem_wdata};

   // RAM byte-lane writes; contents survive reset
   always_ff @(posedge clk) begin
      if (!io_sel_c) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (bus.mem_wmask[i]) begin
               ram[word_idx_c][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            end
         end
      end
   end

   // LED register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         leds <= '0;
      end else if (io_sel_c && (reg_sel_c == IO_LEDS) && bus.mem_wmask[0]) begin
         leds <= bus.mem_wdata[7:0];
      end
   end

   // Free-running cycle counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycles <= '0;
      end else begin
         cycles <= cycles + BUS_W'(1);
      end
   end

   // Read mux; sees pre-edge state, giving read-before-write
   always_comb begin
      rdata_next_c = bus.mem_rdata;
      if (bus.mem_rstrb) begin
         if (!io_sel_c) begin
            rdata_next_c = ram[word_idx_c];
         end else begin
            case (reg_sel_c)
               IO_LEDS:        rdata_next_c = {(BUS_W-8)'(0), leds};
               IO_UART_STATUS: rdata_next_c = {(BUS_W-1)'(0), uart_busy};
               IO_CYCLES:      rdata_next_c = cycles;
               default:        rdata_next_c = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.mem_rdata <= '0;
      end else begin
         bus.mem_rdata <= rdata_next_c;
      end
   end

   uart_tx_8n1 #(
      .CLK_DIV (CLK_DIV)
   ) u_uart (
      .clk   (clk),
      .rstn  (rstn),
      .start (uart_start_c),
      .data  (bus.mem_wdata[7:0]),
      .busy  (uart_busy),
      .tx    (uart_tx)
   );

endmodule
